mem_arbiter: RTL and testbench

Shared-memory arbiter between the per-core icaches and dcaches and the single RAM port. It grants one requester at a time and holds the grant across a dcache two-word burst so fetch or writeback pairs are never interleaved. It drives the RAM strobes, address and store data from the owner and returns per-requester wait signals. It sits between the caches and RAM in the multicore top level.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM subsystem: RAM handshake state, arbiter FSM state
// and small helpers that classify RAM responses.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int DEF_CPUS        = 2;
  localparam int DEF_BURST_WORDS = 2;

  // ACCESS and ERROR both end the current access from the requester's point of view.
  function automatic logic ram_done(input ramstate_t st);
    ram_done = (st == ACCESS) || (st == ERROR);
  endfunction

  function automatic logic ram_error(input ramstate_t st);
    ram_error = (st == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response lanes and the single RAM port, bundled for the arbiter.
// The arbiter connects through the slave modport; caches/RAM model use master.
interface mem_arbiter_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;

  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;

  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  cpu_types_pkg::ramstate_t ramstate;

  logic                  err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin selector: first requester found scanning upward from last+1 (wrapping).
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic             found_s;
  logic [IDX_W-1:0] pick_s;

  // Scan offsets 1..N so the previous winner is considered last.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int off = 1; off <= N; off++) begin
      logic [IDX_W-1:0] cand_s;
      logic             hit_s;
      cand_s  = IDX_W'((int'(last) + off) % N);
      hit_s   = !found_s && req[cand_s];
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  assign any  = found_s;
  assign pick = pick_s;

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to one icache/dcache requester at a time, holding a
// dcache grant across its burst and returning per-requester wait signals.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = DEF_CPUS,
  parameter int BURST_WORDS = DEF_BURST_WORDS
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNT_W = $clog2(BURST_WORDS) + 1;

  arb_state_t       state_r, state_s;
  logic             is_d_r, is_d_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W-1:0] last_d_r, last_d_s;
  logic [IDX_W-1:0] last_i_r, last_i_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             err_r, err_s;

  logic [CPUS-1:0]  act_d_s;
  logic [CPUS-1:0]  act_i_s;
  logic             d_any_s, i_any_s;
  logic [IDX_W-1:0] d_pick_s, i_pick_s;

  logic             own_ren_s, own_wen_s, own_active_s, done_s;
  logic [31:0]      own_addr_s, own_store_s;

  assign act_d_s = bus.dREN | bus.dWEN;
  assign act_i_s = bus.iREN;

  rr_pick #(.N(CPUS), .IDX_W(IDX_W)) u_pick_d (
    .req  (act_d_s),
    .last (last_d_r),
    .any  (d_any_s),
    .pick (d_pick_s)
  );

  rr_pick #(.N(CPUS), .IDX_W(IDX_W)) u_pick_i (
    .req  (act_i_s),
    .last (last_i_r),
    .any  (i_any_s),
    .pick (i_pick_s)
  );

  // Live view of the current owner's request; a simultaneous read+write is a write.
  always_comb begin
    own_ren_s   = 1'b0;
    own_wen_s   = 1'b0;
    own_addr_s  = 32'h0000_0000;
    own_store_s = 32'h0000_0000;
    if (is_d_r) begin
      own_wen_s   = bus.dWEN[idx_r];
      own_ren_s   = bus.dREN[idx_r] & ~bus.dWEN[idx_r];
      own_addr_s  = bus.daddr[idx_r];
      own_store_s = bus.dstore[idx_r];
    end else begin
      own_ren_s   = bus.iREN[idx_r];
      own_addr_s  = bus.iaddr[idx_r];
    end
  end

  assign own_active_s = own_ren_s | own_wen_s;
  assign done_s       = (state_r == OWN) && own_active_s && ram_done(bus.ramstate);

  // Next-state, grant bookkeeping, burst word counting and sticky error.
  always_comb begin
    state_s  = state_r;
    is_d_s   = is_d_r;
    idx_s    = idx_r;
    last_d_s = last_d_r;
    last_i_s = last_i_r;
    cnt_s    = cnt_r;
    err_s    = err_r | (done_s && ram_error(bus.ramstate));
    case (state_r)
      IDLE: begin
        if (d_any_s) begin
          state_s  = OWN;
          is_d_s   = 1'b1;
          idx_s    = d_pick_s;
          last_d_s = d_pick_s;
          cnt_s    = '0;
        end else if (i_any_s) begin
          state_s  = OWN;
          is_d_s   = 1'b0;
          idx_s    = i_pick_s;
          last_i_s = i_pick_s;
          cnt_s    = '0;
        end else begin
          state_s  = IDLE;
        end
      end
      OWN: begin
        if (done_s) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (!is_d_r || (cnt_r == CNT_W'(BURST_WORDS - 1))) begin
            state_s = IDLE;
          end else begin
            state_s = OWN;
          end
        end else if (!own_active_s) begin
          // Owner withdrew (e.g. flush skipped a clean word): release the port.
          state_s = IDLE;
        end else begin
          state_s = OWN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      is_d_r   <= 1'b0;
      idx_r    <= '0;
      last_d_r <= IDX_W'(CPUS - 1);
      last_i_r <= IDX_W'(CPUS - 1);
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      is_d_r   <= is_d_s;
      idx_r    <= idx_s;
      last_d_r <= last_d_s;
      last_i_r <= last_i_s;
      cnt_r    <= cnt_s;
      err_r    <= err_s;
    end
  end

  // RAM drive, per-requester waits and broadcast load data.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    bus.dwait    = '0;
    bus.iwait    = '0;
    bus.dload    = '0;
    bus.iload    = '0;
    bus.err      = err_r;
    if (state_r == OWN) begin
      bus.ramREN   = own_ren_s;
      bus.ramWEN   = own_wen_s;
      bus.ramaddr  = own_addr_s;
      bus.ramstore = own_store_s;
    end else begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
    end
    for (int k = 0; k < CPUS; k++) begin
      bus.dwait[k] = act_d_s[k] & ~(done_s & is_d_r & (idx_r == IDX_W'(k)));
      bus.iwait[k] = act_i_s[k] & ~(done_s & ~is_d_r & (idx_r == IDX_W'(k)));
      bus.dload[k] = bus.ramload;
      bus.iload[k] = bus.ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test-plan scenarios followed by random traffic, every cycle compared
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int BW   = 2;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.CPUS(CPUS)) bus ();

  mem_arbiter #(.CPUS(CPUS), .BURST_WORDS(BW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: owner -1 = none; otherwise a core index with a dcache/icache flag.
  int  m_own    = -1;
  bit  m_is_d   = 1'b0;
  int  m_words  = 0;
  int  m_last_d = CPUS - 1;
  int  m_last_i = CPUS - 1;
  bit  m_err    = 1'b0;
  bit  m_valid  = 1'b0;

  logic            s_ren, s_wen, s_err;
  logic [31:0]     s_addr, s_store, s_iload0;
  logic [CPUS-1:0] s_dwait, s_iwait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [CPUS-1:0] d_act, i_act, e_dw, e_iw;
    logic            e_ren, e_wen, done;
    logic [31:0]     e_addr, e_store;
    bit              found;
    int              c;
    d_act   = bus.dREN | bus.dWEN;
    i_act   = bus.iREN;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = 32'h0;
    e_store = 32'h0;
    if (m_own >= 0) begin
      if (m_is_d) begin
        e_wen   = bus.dWEN[m_own];
        e_ren   = bus.dREN[m_own] && !bus.dWEN[m_own];
        e_addr  = bus.daddr[m_own];
        e_store = bus.dstore[m_own];
      end else begin
        e_ren   = bus.iREN[m_own];
        e_addr  = bus.iaddr[m_own];
      end
    end
    done = (e_ren || e_wen) && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
    for (int k = 0; k < CPUS; k++) begin
      e_dw[k] = d_act[k] && !(done && m_is_d && m_own == k);
      e_iw[k] = i_act[k] && !(done && !m_is_d && m_own == k);
    end
    #4;
    s_ren    = bus.ramREN;
    s_wen    = bus.ramWEN;
    s_addr   = bus.ramaddr;
    s_store  = bus.ramstore;
    s_dwait  = bus.dwait;
    s_iwait  = bus.iwait;
    s_err    = bus.err;
    s_iload0 = bus.iload[0];
    if (m_valid) begin
      chk("m_ramREN", 64'(s_ren), 64'(e_ren));
      chk("m_ramWEN", 64'(s_wen), 64'(e_wen));
      chk("m_ramaddr", 64'(s_addr), 64'(e_addr));
      chk("m_ramstore", 64'(s_store), 64'(e_store));
      chk("m_dwait", 64'(s_dwait), 64'(e_dw));
      chk("m_iwait", 64'(s_iwait), 64'(e_iw));
      chk("m_err", 64'(s_err), 64'(m_err));
      for (int k = 0; k < CPUS; k++) begin
        chk("m_dload", 64'(bus.dload[k]), 64'(bus.ramload));
        chk("m_iload", 64'(bus.iload[k]), 64'(bus.ramload));
      end
    end
    if (RST) begin
      m_own = -1; m_words = 0; m_last_d = CPUS - 1; m_last_i = CPUS - 1;
      m_err = 1'b0; m_valid = 1'b1;
    end else begin
      if (done && bus.ramstate == ERROR) m_err = 1'b1;
      if (m_own < 0) begin
        found = 1'b0;
        for (int off = 1; off <= CPUS; off++) begin
          c = (m_last_d + off) % CPUS;
          if (!found && d_act[c]) begin
            found = 1'b1; m_own = c; m_is_d = 1'b1; m_last_d = c; m_words = 0;
          end
        end
        for (int off = 1; off <= CPUS; off++) begin
          c = (m_last_i + off) % CPUS;
          if (!found && i_act[c]) begin
            found = 1'b1; m_own = c; m_is_d = 1'b0; m_last_i = c; m_words = 0;
          end
        end
      end else if (done) begin
        m_words++;
        if (!m_is_d || m_words == BW) m_own = -1;
      end else if (!(e_ren || e_wen)) begin
        m_own = -1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int r;
    RST = 1'b1;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'h0; bus.ramstate = FREE;
    @(posedge CLK);
    #1;

    // Reset: active requester still sees wait.
    bus.iREN = 2'b01;
    step();
    step();
    chk("rst_ren", 64'(s_ren), 64'(1'b0));
    chk("rst_iwait", 64'(s_iwait), 64'(2'b01));
    chk("rst_err", 64'(s_err), 64'(1'b0));

    // Single icache 0 read.
    RST = 1'b0;
    bus.iaddr[0] = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_0001;
    step();
    chk("t1_c1_ren", 64'(s_ren), 64'(1'b0));
    step();
    chk("t1_c2_ren", 64'(s_ren), 64'(1'b1));
    chk("t1_c2_addr", 64'(s_addr), 64'(32'h40));
    chk("t1_c2_iwait", 64'(s_iwait), 64'(2'b00));
    chk("t1_c2_iload", 64'(s_iload0), 64'(32'hCAFE_0001));
    bus.iREN = 2'b00;
    step();
    chk("t1_idle_ren", 64'(s_ren), 64'(1'b0));

    // dcache 0 two-word fetch with icache 1 waiting.
    bus.dREN = 2'b01; bus.daddr[0] = 32'h100;
    bus.iREN = 2'b10; bus.iaddr[1] = 32'h200;
    step();
    step();
    chk("t2_w0_addr", 64'(s_addr), 64'(32'h100));
    chk("t2_w0_dwait", 64'(s_dwait), 64'(2'b00));
    bus.daddr[0] = 32'h104;
    step();
    chk("t2_w1_addr", 64'(s_addr), 64'(32'h104));
    chk("t2_w1_iwait", 64'(s_iwait), 64'(2'b10));
    bus.dREN = 2'b00;
    step();
    chk("t2_gap_ren", 64'(s_ren), 64'(1'b0));
    step();
    chk("t2_i1_addr", 64'(s_addr), 64'(32'h200));
    chk("t2_i1_iwait", 64'(s_iwait), 64'(2'b00));
    bus.iREN = 2'b00;
    step();

    // Both dcaches continuously: bursts alternate, icache 0 starves.
    bus.dREN = 2'b11; bus.daddr[0] = 32'h1000; bus.daddr[1] = 32'h2000;
    bus.iREN = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_ren", 64'(s_ren), 64'((i % 3) != 0));
      chk("t3_addr", 64'(s_addr),
          ((i % 3) == 0) ? 64'h0 : (((i / 3) % 2) == 0 ? 64'h2000 : 64'h1000));
      chk("t3_iwait", 64'(s_iwait[0]), 64'(1'b1));
    end
    bus.dREN = 2'b00; bus.iREN = 2'b00;
    step();
    chk("t4_drop_dwait", 64'(s_dwait), 64'(2'b00));
    chk("t4_drop_ren", 64'(s_ren), 64'(1'b0));

    // Flush: one dirty word written, the next skipped.
    step();
    chk("t4_clean_dwait", 64'(s_dwait), 64'(2'b00));
    bus.dWEN = 2'b01; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'h55;
    step();
    step();
    chk("t4_wen", 64'(s_wen), 64'(1'b1));
    chk("t4_store", 64'(s_store), 64'(32'h55));
    bus.dWEN = 2'b00;
    step();
    chk("t4_skip_dwait", 64'(s_dwait), 64'(2'b00));
    chk("t4_skip_wen", 64'(s_wen), 64'(1'b0));
    bus.dREN = 2'b10; bus.daddr[1] = 32'h400;
    step();
    step();
    chk("t4_next_addr", 64'(s_addr), 64'(32'h400));
    bus.dREN = 2'b00;
    step();

    // ERROR on a dcache write.
    bus.dWEN = 2'b01; bus.daddr[0] = 32'h3100; bus.dstore[0] = 32'hE; bus.ramstate = ERROR;
    step();
    step();
    chk("t5_addr", 64'(s_addr), 64'(32'h3100));
    chk("t5_dwait", 64'(s_dwait), 64'(2'b00));
    chk("t5_err_pre", 64'(s_err), 64'(1'b0));
    bus.dWEN = 2'b00; bus.ramstate = ACCESS;
    step();
    chk("t5_err_set", 64'(s_err), 64'(1'b1));
    step();
    chk("t5_err_hold", 64'(s_err), 64'(1'b1));

    // Reset mid-burst, then re-grant.
    bus.dREN = 2'b01; bus.daddr[0] = 32'h500; bus.ramstate = BUSY;
    step();
    step();
    chk("t6_own_ren", 64'(s_ren), 64'(1'b1));
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    chk("t6_ren", 64'(s_ren), 64'(1'b0));
    chk("t6_err", 64'(s_err), 64'(1'b0));
    chk("t6_dwait", 64'(s_dwait), 64'(2'b01));
    bus.ramstate = ACCESS;
    step();
    chk("t6_regrant", 64'(s_addr), 64'(32'h500));
    bus.daddr[0] = 32'h504;
    step();
    chk("t6_word1", 64'(s_addr), 64'(32'h504));
    chk("t6_word1_ren", 64'(s_ren), 64'(1'b1));
    bus.dREN = 2'b00;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RST      = ($urandom_range(0, 99) == 0);
      bus.iREN = CPUS'($urandom);
      bus.dREN = CPUS'($urandom);
      bus.dWEN = CPUS'($urandom & $urandom);
      for (int k = 0; k < CPUS; k++) begin
        bus.iaddr[k]  = $urandom;
        bus.daddr[k]  = $urandom;
        bus.dstore[k] = $urandom;
      end
      bus.ramload = $urandom;
      r = int'($urandom_range(0, 39));
      bus.ramstate = (r == 0) ? ERROR : (r < 13) ? BUSY : (r < 16) ? FREE : ACCESS;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
